// File: rtl/lane_burst_tx.sv
// Eight-lane round-robin burst transmitter: grants one requesting lane, forwards up to
// MAX_BURST beats through a single output register, and ends early on in_last or idle timeout.
module lane_burst_tx #(
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_i,
  input  logic       abort_i,
  output logic [7:0] grant_o,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  input  logic       in_last_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  output logic [7:0] out_lane_o,
  output logic       out_last_o,
  input  logic       out_ready_i,
  output logic       err_o
);

  typedef enum logic [1:0] {IDLE, GRANT, BURST, DRAIN} state_t;

  state_t     state_q;
  logic [2:0] ptr_q;
  logic [2:0] gidx_q;
  logic [7:0] grant_q;
  logic [3:0] beat_cnt_q;
  logic [7:0] idle_cnt_q;
  logic       out_valid_q;
  logic [7:0] out_data_q;
  logic [7:0] out_lane_q;
  logic       out_last_q;
  logic       err_q;
  logic       started_q;

  logic [2:0] sel_idx_d;
  logic [7:0] idle_cnt_d;
  logic       accept;
  logic       last_beat;

  // Lowest offset from ptr wins, so iterate from the far end and let nearer hits overwrite.
  function automatic logic [2:0] first_req(input logic [7:0] req, input logic [2:0] ptr);
    logic [2:0] idx;
    logic [2:0] sel;
    sel = ptr;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (req[idx]) sel = idx;
    end
    return sel;
  endfunction

  assign in_ready_o = (state_q == BURST) && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign last_beat  = in_last_i || (beat_cnt_q == 4'(MAX_BURST - 1));
  assign idle_cnt_d = in_valid_i ? 8'd0 : idle_cnt_q + 8'd1;
  assign sel_idx_d  = first_req(req_i, ptr_q);

  assign grant_o     = grant_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_lane_o  = out_lane_q;
  assign out_last_o  = out_last_q;
  assign err_o       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      gidx_q      <= 3'd0;
      grant_q     <= 8'd0;
      beat_cnt_q  <= 4'd0;
      idle_cnt_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_lane_q  <= 8'd0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      started_q   <= 1'b0;
    end else begin
      started_q <= 1'b1;
      err_q     <= 1'b0;
      if (abort_i) begin
        state_q     <= IDLE;
        grant_q     <= 8'd0;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            // started_q holds off the first grant until the second edge after reset release.
            if (started_q && (req_i != 8'd0)) begin
              gidx_q  <= sel_idx_d;
              grant_q <= 8'd1 << sel_idx_d;
              state_q <= GRANT;
            end
          end
          GRANT: begin
            beat_cnt_q <= 4'd0;
            idle_cnt_q <= 8'd0;
            state_q    <= BURST;
          end
          BURST: begin
            idle_cnt_q <= idle_cnt_d;
            if (out_valid_q && out_ready_i) out_valid_q <= 1'b0;
            if (accept) begin
              out_valid_q <= 1'b1;
              out_data_q  <= in_data_i;
              out_lane_q  <= grant_q;
              out_last_q  <= last_beat;
              beat_cnt_q  <= beat_cnt_q + 4'd1;
              if (last_beat) state_q <= DRAIN;
            end else if (idle_cnt_d == 8'(TIMEOUT)) begin
              err_q   <= 1'b1;
              state_q <= DRAIN;
            end
          end
          DRAIN: begin
            if (!out_valid_q || out_ready_i) begin
              out_valid_q <= 1'b0;
              grant_q     <= 8'd0;
              ptr_q       <= gidx_q + 3'd1;
              state_q     <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lane_burst_tx.sv
// Directed bench for lane_burst_tx: vector table for the main bursts plus hand-written
// sequences for timeout, abort and asynchronous reset.
module tb_lane_burst_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       abort;
  logic [7:0] grant;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] out_lane;
  logic       out_last;
  logic       out_ready;
  logic       err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lane_burst_tx #(.MAX_BURST(4), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .abort_i    (abort),
    .grant_o    (grant),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_lane_o (out_lane),
    .out_last_o (out_last),
    .out_ready_i(out_ready),
    .err_o      (err)
  );

  typedef struct {
    logic [7:0] req;
    logic       iv;
    logic [7:0] d;
    logic       il;
    logic       ordy;
    logic       exp_rdy;
    logic [7:0] exp_gnt;
    logic       exp_ov;
    logic [7:0] exp_data;
    logic [7:0] exp_lane;
    logic       exp_last;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(logic [7:0] r, logic iv, logic [7:0] d, logic il, logic ordy,
                              logic rdy, logic [7:0] g, logic ov, logic [7:0] od,
                              logic [7:0] ol, logic last);
    vec_t v;
    v.req = r; v.iv = iv; v.d = d; v.il = il; v.ordy = ordy;
    v.exp_rdy = rdy; v.exp_gnt = g; v.exp_ov = ov; v.exp_data = od;
    v.exp_lane = ol; v.exp_last = last;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " grant"}, grant, 8'h00);
    chk({tag, " out_valid"}, {7'd0, out_valid}, 8'h00);
    chk({tag, " out_data"}, out_data, 8'h00);
    chk({tag, " out_lane"}, out_lane, 8'h00);
    chk({tag, " out_last"}, {7'd0, out_last}, 8'h00);
    chk({tag, " err"}, {7'd0, err}, 8'h00);
    chk({tag, " in_ready"}, {7'd0, in_ready}, 8'h00);
  endtask

  initial begin
    // req, iv, data, last, ordy | in_ready, grant, ov, out_data, out_lane, out_last
    tbl[0]  = mk(8'h05, 0, 8'h00, 0, 1,  0, 8'h00, 0, 8'h00, 8'h00, 0);
    tbl[1]  = mk(8'h05, 0, 8'h00, 0, 1,  0, 8'h01, 0, 8'h00, 8'h00, 0);
    tbl[2]  = mk(8'h05, 0, 8'h00, 0, 1,  0, 8'h01, 0, 8'h00, 8'h00, 0);
    tbl[3]  = mk(8'h05, 1, 8'hA1, 0, 1,  1, 8'h01, 1, 8'hA1, 8'h01, 0);
    tbl[4]  = mk(8'h05, 1, 8'hA2, 1, 1,  1, 8'h01, 1, 8'hA2, 8'h01, 1);
    tbl[5]  = mk(8'h05, 0, 8'h00, 0, 1,  0, 8'h00, 0, 8'hA2, 8'h01, 1);
    tbl[6]  = mk(8'h05, 0, 8'h00, 0, 1,  0, 8'h04, 0, 8'hA2, 8'h01, 1);
    tbl[7]  = mk(8'h00, 0, 8'h00, 0, 1,  0, 8'h04, 0, 8'hA2, 8'h01, 1);
    tbl[8]  = mk(8'h00, 1, 8'hB1, 0, 0,  1, 8'h04, 1, 8'hB1, 8'h04, 0);
    for (int i = 9; i <= 13; i++)
      tbl[i] = mk(8'h00, 1, 8'hB2, 0, 0,  0, 8'h04, 1, 8'hB1, 8'h04, 0);
    tbl[14] = mk(8'h00, 1, 8'hB2, 0, 1,  1, 8'h04, 1, 8'hB2, 8'h04, 0);
    tbl[15] = mk(8'h00, 1, 8'hB3, 1, 1,  1, 8'h04, 1, 8'hB3, 8'h04, 1);
    tbl[16] = mk(8'h00, 0, 8'h00, 0, 1,  0, 8'h00, 0, 8'hB3, 8'h04, 1);
    tbl[17] = mk(8'h08, 0, 8'h00, 0, 1,  0, 8'h08, 0, 8'hB3, 8'h04, 1);
    tbl[18] = mk(8'h08, 0, 8'h00, 0, 1,  0, 8'h08, 0, 8'hB3, 8'h04, 1);
    tbl[19] = mk(8'h00, 1, 8'hC1, 0, 1,  1, 8'h08, 1, 8'hC1, 8'h08, 0);
    tbl[20] = mk(8'h00, 1, 8'hC2, 0, 1,  1, 8'h08, 1, 8'hC2, 8'h08, 0);
    tbl[21] = mk(8'h00, 1, 8'hC3, 0, 1,  1, 8'h08, 1, 8'hC3, 8'h08, 0);
    tbl[22] = mk(8'h00, 1, 8'hC4, 0, 1,  1, 8'h08, 1, 8'hC4, 8'h08, 1);
    tbl[23] = mk(8'h00, 1, 8'hC5, 0, 1,  0, 8'h00, 0, 8'hC4, 8'h08, 1);
    tbl[24] = mk(8'h00, 1, 8'hC6, 0, 1,  0, 8'h00, 0, 8'hC4, 8'h08, 1);

    rst_n = 1'b0; req = 8'h00; abort = 1'b0; in_valid = 1'b0;
    in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Lane 0 two-beat burst, lane 2 stalled burst, lane 3 capped at MAX_BURST.
    for (int i = 0; i < 25; i++) begin
      req = tbl[i].req; in_valid = tbl[i].iv; in_data = tbl[i].d;
      in_last = tbl[i].il; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), {7'd0, in_ready}, {7'd0, tbl[i].exp_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d grant", i), grant, tbl[i].exp_gnt);
      chk($sformatf("v%0d out_valid", i), {7'd0, out_valid}, {7'd0, tbl[i].exp_ov});
      chk($sformatf("v%0d out_data", i), out_data, tbl[i].exp_data);
      chk($sformatf("v%0d out_lane", i), out_lane, tbl[i].exp_lane);
      chk($sformatf("v%0d out_last", i), {7'd0, out_last}, {7'd0, tbl[i].exp_last});
      chk($sformatf("v%0d err", i), {7'd0, err}, 8'h00);
    end

    // Timeout: lane 4 granted (ptr=4), source never valid.
    in_valid = 1'b0; req = 8'h10;
    step();
    chk("to grant", grant, 8'h10);
    req = 8'h00;
    step();
    for (int k = 1; k <= 15; k++) begin
      step();
      chk($sformatf("to err k%0d", k), {7'd0, err}, (k == 15) ? 8'h01 : 8'h00);
    end
    chk("to no beat", {7'd0, out_valid}, 8'h00);
    chk("to grant held", grant, 8'h10);
    step();
    chk("to err cleared", {7'd0, err}, 8'h00);
    chk("to grant cleared", grant, 8'h00);

    // Abort with an accepted beat and a stalled sink; ptr stays 5 while lane 6 was granted.
    req = 8'h40;
    step();
    chk("ab grant", grant, 8'h40);
    req = 8'h00;
    step();
    abort = 1'b1; in_valid = 1'b1; in_data = 8'hD1; out_ready = 1'b0;
    #1;
    chk("ab in_ready", {7'd0, in_ready}, 8'h01);
    step();
    chk("ab out_valid", {7'd0, out_valid}, 8'h00);
    chk("ab grant", grant, 8'h00);
    chk("ab err", {7'd0, err}, 8'h00);
    abort = 1'b0; in_valid = 1'b0; req = 8'hA0;
    step();
    chk("ab ptr kept", grant, 8'h20);

    // Asynchronous reset with a pending beat, then wrap scan from ptr=0 to lane 7.
    req = 8'h00;
    step();
    in_valid = 1'b1; in_data = 8'hE1; out_ready = 1'b0;
    step();
    chk("rs beat", out_data, 8'hE1);
    chk("rs valid", {7'd0, out_valid}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async rst");
    in_valid = 1'b0; req = 8'h80;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("rs first edge", grant, 8'h00);
    step();
    chk("rs wrap grant", grant, 8'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
